dmem_port: RTL and testbench
============================

# dmem_port

Memory-stage data-bus initiator that sits between the EX/MEM pipeline latch and the MEM/WB boundary. Takes the latched access controls, runs a req/gnt/rvalid transaction on the data-memory bus, and holds the pipeline with `stall_o` until the transaction completes. Registers the write-back result (ALU result or load data) for the write-back stage.

## Interface
- `XLEN`, 32, data and address width.
- `RA_W`, 32, register-file write-address width; matches the EX/MEM latch.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  async active-low reset.
- `rf_we_i`  in  1  EX/MEM register-file write enable.
- `mem_we_i`  in  1  store request.
- `mem2rf_i`  in  1  load request; write-back takes memory data.
- `mem_wdata_i`  in  XLEN  store data.
- `rf_waddr_i`  in  RA_W  destination register.
- `alu_result_i`  in  XLEN  memory address, or the write-back value when not loading.
- `dbus_req_o`  out  1  bus request.
- `dbus_we_o`  out  1  1 = write.
- `dbus_addr_o`  out  XLEN  word address (`alu_result_i`).
- `dbus_wdata_o`  out  XLEN  store data.
- `dbus_gnt_i`  in  1  request accepted.
- `dbus_rvalid_i`  in  1  read data valid.
- `dbus_rdata_i`  in  XLEN  read data.
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- `wb_rf_we_o`  out  1  registered write-back enable.
- `wb_rf_waddr_o`  out  RA_W  registered destination.
- `wb_rf_wdata_o`  out  XLEN  registered write-back data.
- `fault_o`  out  1  misaligned-access pulse; present only with the macro.

## Operation
- `access = mem_we_i | mem2rf_i`.
  - `mem_we_i` and `mem2rf_i` both high is illegal.
  - In that case the store wins and `mem2rf_i` is ignored.
- FSM states: `IDLE`, `REQ`, `RESP`.
- `IDLE`:
  - `dbus_req_o = access`; the request is asserted combinationally in the same cycle.
  - If `gnt` arrives in that cycle:
    - store: complete, no stall;
    - load: go to `RESP`.
  - If no `gnt`: go to `REQ`.
- `REQ`:
  - Hold `req` and all bus signals stable.
  - On `gnt`:
    - store: complete, return to `IDLE`;
    - load: go to `RESP`.
- `RESP`:
  - `req` is low.
  - On `rvalid`: complete, capture `dbus_rdata_i`, return to `IDLE`.
- `rvalid` arriving in the same cycle as `gnt`: not supported; the earliest valid `rvalid` is the cycle after `gnt`.
- `stall_o = access & ~complete_this_cycle`.
- Write-back register, updated every cycle:
  - Cycle with `~stall_o`: load `wb_rf_we_o = rf_we_i`, `wb_rf_waddr_o = rf_waddr_i`.
  - `wb_rf_wdata_o = mem2rf_i ? dbus_rdata_i : alu_result_i`.
  - Cycle with `stall_o`: load a bubble, `wb_rf_we_o = 0`; other fields hold.
- A store never writes the register file in practice: the upstream decoder drives `rf_we_i = 0`. This block does not enforce it.
- `dbus_we_o = mem_we_i`, `dbus_addr_o = alu_result_i`, `dbus_wdata_o = mem_wdata_i`. These are valid whenever `req` is high.

## Timing
- Reset:
  - FSM goes to `IDLE`.
  - `wb_rf_we_o = 0`, `wb_rf_waddr_o = 0`, `wb_rf_wdata_o = 0`, `fault_o = 0`.
  - `dbus_req_o = 0` while `rst_n` is low.
- Store with zero-wait `gnt`: 0 stall cycles; the `wb` bubble is irrelevant.
- Load with `gnt` in cycle 0 and `rvalid` in cycle 1: `stall_o` is high in cycle 0 only. `wb` is registered at the end of cycle 1.
- Each extra `gnt` wait cycle or `rvalid` wait cycle adds one stall cycle.
- Non-access instructions: pass through in 1 cycle, no stall.
- Reset mid-transaction: the FSM aborts to `IDLE` immediately. Any `rvalid` still outstanding after reset is ignored, because `RESP` is not active.
- EX/MEM inputs are held stable by upstream while `stall_o` is high.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - In `IDLE`, an access with `alu_result_i[1:0] != 0` issues no `req` and no stall.
  - It loads a bubble (`wb_rf_we_o = 0`).
  - `fault_o` pulses high for exactly one cycle, registered (the cycle after detection).
- Macro undefined:
  - `fault_o` port is absent.
  - Address bits [1:0] are passed through unchanged; the bus handles alignment.

## Structure
- Shared package `core_pkg`:
  - `dmem_state_e` enum (`IDLE`/`REQ`/`RESP`);
  - `XLEN` default constant.
- Sub-module `mw_latch`: the write-back register with a bubble input.
- FSM and stall logic live in `dmem_port`.

## Test plan
- No access, `alu_result_i=0x1234`, `rf_we_i=1`, `rf_waddr_i=5` → `stall_o=0`, no `req`; next cycle `wb`=(1, 5, 0x1234).
- Store to 0x100, data 0xDEADBEEF, `gnt` held low 2 cycles → `req` high with stable address/data for 3 cycles; `stall_o` high 2 cycles; `wb_rf_we_o=0`.
- Load from 0x200, zero-wait `gnt`, `rvalid` 3 cycles later with 0xCAFEF00D, `rf_waddr=7` → `stall_o` high 3 cycles, then `wb`=(1, 7, 0xCAFEF00D).
- Back-to-back loads, each with 1-cycle `rvalid` latency → each load stalls exactly 1 cycle; `wb` order is preserved.
- `rst_n` asserted while in `RESP`, `rvalid` arrives after release → FSM in `IDLE`, `wb` all zeros, `rvalid` ignored, `stall_o=0`.
- With `DMEM_MISALIGN_TRAP_EN`, load from 0x202 → no `req`, `stall_o=0`, `fault_o` one-cycle pulse, `wb_rf_we_o=0`.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared core types and constants for the memory stage
package core_pkg;
  localparam int XLEN_DEFAULT = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/mw_latch.sv
// mw_latch: MEM/WB write-back register; a bubble clears the write enable and holds the rest
module mw_latch #(
  parameter int XLEN = core_pkg::XLEN_DEFAULT,
  parameter int RA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bubble,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_waddr,
  output logic [XLEN-1:0] wb_wdata
);
  // capture the write-back triple, or insert a bubble while the stage is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else begin
      wb_we <= bubble ? 1'b0 : we;
      if (!bubble) begin
        wb_waddr <= waddr;
        wb_wdata <= wdata;
      end
    end
  end
endmodule

// File: rtl/dmem_port.sv
// dmem_port: memory-stage data-bus initiator with stall and write-back register; DMEM_MISALIGN_TRAP_EN adds a misaligned-access trap
module dmem_port #(
  parameter int XLEN = core_pkg::XLEN_DEFAULT,
  parameter int RA_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rf_we_i,
  input  logic            mem_we_i,
  input  logic            mem2rf_i,
  input  logic [XLEN-1:0] mem_wdata_i,
  input  logic [RA_W-1:0] rf_waddr_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  output logic            stall_o,
  output logic            wb_rf_we_o,
  output logic [RA_W-1:0] wb_rf_waddr_o,
  output logic [XLEN-1:0] wb_rf_wdata_o
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic            fault_o
`endif
);
  import core_pkg::*;
  dmem_state_e state, state_nxt;
  logic access, is_load, mis, req, done;
  // a store wins over a simultaneous load request
  assign access  = mem_we_i | mem2rf_i;
  assign is_load = mem2rf_i & ~mem_we_i;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (state == IDLE) & access & (alu_result_i[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign req     = (state == REQ) | ((state == IDLE) & access & ~mis);
  assign done    = (state == RESP) ? dbus_rvalid_i : (req & dbus_gnt_i & mem_we_i);
  assign stall_o = access & ~done & ~mis;
  assign dbus_req_o   = req & rst_n;
  assign dbus_we_o    = mem_we_i;
  assign dbus_addr_o  = alu_result_i;
  assign dbus_wdata_o = mem_wdata_i;
  // next state: loads wait in RESP for rvalid, ungranted requests wait in REQ
  always_comb
    state_nxt = (state == RESP) ? (dbus_rvalid_i ? IDLE : RESP) :
                !req            ? IDLE :
                !dbus_gnt_i     ? REQ  :
                mem_we_i        ? IDLE : RESP;
  // state register; reset aborts any outstanding transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
`ifdef DMEM_MISALIGN_TRAP_EN
  // one-cycle registered fault pulse for a misaligned access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_o <= 1'b0;
    else        fault_o <= mis;
  end
`endif
  mw_latch #(.XLEN(XLEN), .RA_W(RA_W)) u_mw (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble  (stall_o | mis),
    .we      (rf_we_i),
    .waddr   (rf_waddr_i),
    .wdata   (is_load ? dbus_rdata_i : alu_result_i),
    .wb_we   (wb_rf_we_o),
    .wb_waddr(wb_rf_waddr_o),
    .wb_wdata(wb_rf_wdata_o)
  );
endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: directed self-checking bench for dmem_port
module tb_dmem_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we = 1'b0, mem_we = 1'b0, mem2rf = 1'b0;
  logic [31:0] mem_wdata = '0, waddr = '0, alu = '0;
  logic        req, dwe, gnt = 1'b0, rvalid = 1'b0, stall, wb_we;
  logic [31:0] daddr, dwdata, rdata = '0, wb_waddr, wb_wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        fault;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dmem_port dut (
    .clk(clk), .rst_n(rst_n), .rf_we_i(rf_we), .mem_we_i(mem_we), .mem2rf_i(mem2rf),
    .mem_wdata_i(mem_wdata), .rf_waddr_i(waddr), .alu_result_i(alu),
    .dbus_req_o(req), .dbus_we_o(dwe), .dbus_addr_o(daddr), .dbus_wdata_o(dwdata),
    .dbus_gnt_i(gnt), .dbus_rvalid_i(rvalid), .dbus_rdata_i(rdata), .stall_o(stall),
    .wb_rf_we_o(wb_we), .wb_rf_waddr_o(wb_waddr), .wb_rf_wdata_o(wb_wdata)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .fault_o(fault)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic [31:0] a, input logic [31:0] wa, input logic [31:0] d, input int n);
    mem2rf = 1'b1; mem_we = 1'b0; rf_we = 1'b1; waddr = wa; alu = a;
    for (int i = 0; i <= n; i++) begin
      gnt = (i == 0); rvalid = (i == n); rdata = (i == n) ? d : 32'h0;
      #1;
      chk("ld_stall", stall, i < n);
      chk("ld_req", req, i == 0);
      if (i == 0) chk("ld_addr", daddr, a);
      tick();
      if (i < n) chk("ld_bubble", wb_we, 0);
    end
    gnt = 1'b0; rvalid = 1'b0; rdata = '0; mem2rf = 1'b0;
    chk("ld_wb_we", wb_we, 1);
    chk("ld_wb_waddr", wb_waddr, wa);
    chk("ld_wb_wdata", wb_wdata, d);
  endtask

  initial begin
    mem2rf = 1'b1; alu = 32'h40;
    #12;
    chk("rst_req", req, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_waddr", wb_waddr, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    mem2rf = 1'b0; alu = '0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    // non-access pass-through
    rf_we = 1'b1; waddr = 5; alu = 32'h1234;
    #1;
    chk("pass_stall", stall, 0);
    chk("pass_req", req, 0);
    tick();
    chk("pass_wb_we", wb_we, 1);
    chk("pass_wb_waddr", wb_waddr, 5);
    chk("pass_wb_wdata", wb_wdata, 32'h1234);
    // store with two gnt wait cycles
    rf_we = 1'b0; mem_we = 1'b1; alu = 32'h100; mem_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      gnt = (i == 2);
      #1;
      chk("st_req", req, 1);
      chk("st_we", dwe, 1);
      chk("st_addr", daddr, 32'h100);
      chk("st_wdata", dwdata, 32'hDEADBEEF);
      chk("st_stall", stall, i < 2);
      tick();
    end
    gnt = 1'b0; mem_we = 1'b0;
    chk("st_wb_we", wb_we, 0);
    #1;
    chk("st_idle_req", req, 0);
    // load with zero-wait gnt and rvalid three cycles later
    load_op(32'h200, 7, 32'hCAFEF00D, 3);
    // back-to-back loads with one-cycle rvalid latency
    load_op(32'h300, 3, 32'h11111111, 1);
    load_op(32'h304, 4, 32'h22222222, 1);
    // reset while waiting in RESP
    mem2rf = 1'b1; rf_we = 1'b1; waddr = 9; alu = 32'h400; gnt = 1'b1;
    tick();
    gnt = 1'b0;
    #1;
    chk("abort_resp_stall", stall, 1);
    chk("abort_resp_req", req, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_wb_we", wb_we, 0);
    chk("abort_wb_waddr", wb_waddr, 0);
    chk("abort_wb_wdata", wb_wdata, 0);
    mem2rf = 1'b0; rf_we = 1'b0; alu = '0; waddr = '0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    rvalid = 1'b1; rdata = 32'h5555;
    #1;
    chk("late_rv_stall", stall, 0);
    chk("late_rv_req", req, 0);
    tick();
    rvalid = 1'b0; rdata = '0;
    chk("late_rv_wb_we", wb_we, 0);
    chk("late_rv_wb_wdata", wb_wdata, 0);
    load_op(32'h500, 10, 32'h0000BEEF, 1);
`ifdef DMEM_MISALIGN_TRAP_EN
    mem2rf = 1'b1; rf_we = 1'b1; waddr = 6; alu = 32'h202;
    #1;
    chk("mis_req", req, 0);
    chk("mis_stall", stall, 0);
    chk("mis_fault_pre", fault, 0);
    tick();
    mem2rf = 1'b0; rf_we = 1'b0;
    chk("mis_fault", fault, 1);
    chk("mis_wb_we", wb_we, 0);
    tick();
    chk("mis_fault_end", fault, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
